// File: rtl/chan_mux_seq.sv
// rtl/chan_mux_seq.sv - registered N-channel display selector with blanking and auto-scan
// Any channel change blanks the output for BLANK cycles before the new source is shown.
module chan_mux_seq #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int BLANK    = 2,
  parameter int DWELL    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      auto,
  output logic [WIDTH-1:0]          result,
  output logic [SEL_W-1:0]          active,
  output logic                      valid
);

  localparam int BCW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [BCW-1:0]   BLANK_LAST = BCW'(BLANK - 1);
  localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_LIM     = (SEL_W + 1)'(CHANNELS);

  typedef enum logic {S_BLANK, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [DCW-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] cur_data;
  logic [SEL_W-1:0] next_ch;
  logic             sel_ok;
  logic             do_switch;
  logic [SEL_W-1:0] target;

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active_q == SEL_W'(i)) cur_data = ch_data[i*WIDTH +: WIDTH];
    end
  end

  // Explicit wrap so non-power-of-two channel counts scan correctly
  assign next_ch = (active_q == CH_LAST) ? '0 : active_q + SEL_W'(1);
  assign sel_ok  = ({1'b0, sel} < CH_LIM) && (sel != active_q);

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    active_d    = active_q;
    result_d    = '0;
    valid_d     = 1'b0;
    do_switch   = 1'b0;
    target      = active_q;
    unique case (state_q)
      S_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = S_HOLD;
          blank_cnt_d = '0;
          dwell_cnt_d = '0;
          result_d    = cur_data;
          valid_d     = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt_q + BCW'(1);
        end
      end
      S_HOLD: begin
        result_d = cur_data;
        valid_d  = 1'b1;
        if (auto) begin
          if (dwell_cnt_q == DWELL_LAST) begin
            do_switch = 1'b1;
            target    = next_ch;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DCW'(1);
          end
        end else begin
          // Held at zero in manual mode so entering auto starts a fresh dwell
          dwell_cnt_d = '0;
          if (sel_ok) begin
            do_switch = 1'b1;
            target    = sel;
          end
        end
        if (do_switch) begin
          active_d    = target;
          state_d     = S_BLANK;
          blank_cnt_d = '0;
          dwell_cnt_d = '0;
          result_d    = '0;
          valid_d     = 1'b0;
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BLANK;
      blank_cnt_q <= '0;
      dwell_cnt_q <= '0;
      active_q    <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      active_q    <= active_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
    end
  end

  assign result = result_q;
  assign active = active_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_chan_mux_seq.sv
// tb/tb_chan_mux_seq.sv - randomized self-checking bench for chan_mux_seq
`timescale 1ns/1ps
module tb_chan_mux_seq;

  localparam int W  = 3;
  localparam int CH = 3;
  localparam int SW = 2;
  localparam int BL = 2;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*W-1:0] ch_data = '0;
  logic [SW-1:0]   sel = '0;
  logic            auto = 1'b0;
  logic [W-1:0]    result;
  logic [SW-1:0]   active;
  logic            valid;

  int n_checks = 0;
  int n_errors = 0;

  chan_mux_seq #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .BLANK(BL), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .sel(sel), .auto(auto),
    .result(result), .active(active), .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference: count remaining blank cycles and age of the current hold
  int           m_active = 0;
  int           m_blank_left = BL;
  int           m_hold = 0;
  logic [W-1:0] m_result = '0;
  logic         m_valid = 1'b0;

  function automatic logic [W-1:0] chan(input int i);
    logic [CH*W-1:0] d;
    d = ch_data;
    return d[i*W +: W];
  endfunction

  always @(posedge clk) begin
    int tgt;
    if (rst) begin
      m_active = 0; m_blank_left = BL; m_hold = 0; m_result = '0; m_valid = 1'b0;
    end else if (m_blank_left > 0) begin
      m_blank_left = m_blank_left - 1;
      if (m_blank_left == 0) begin
        m_result = chan(m_active); m_valid = 1'b1; m_hold = 0;
      end else begin
        m_result = '0; m_valid = 1'b0;
      end
    end else begin
      tgt = -1;
      if (auto) begin
        if (m_hold == DW - 1) tgt = (m_active + 1) % CH;
        m_hold = m_hold + 1;
      end else begin
        m_hold = 0;
        if (int'(sel) < CH && int'(sel) != m_active) tgt = int'(sel);
      end
      if (tgt >= 0) begin
        m_active = tgt; m_blank_left = BL; m_result = '0; m_valid = 1'b0;
      end else begin
        m_result = chan(m_active);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("result", 32'(result), 32'(m_result));
    check("active", 32'(active), 32'(m_active));
    check("valid", 32'(valid), 32'(m_valid));
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 40 && !valid; i++) tick();
    check("wait_hold", 32'(valid), 32'd1);
  endtask

  task automatic set_chan(input int i, input logic [W-1:0] v);
    ch_data[i*W +: W] = v;
  endtask

  initial begin
    // Reset and first display of channel 0
    ch_data = CH*W'($urandom);
    set_chan(0, 3'b101);
    repeat (3) tick();
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    tick();
    check("blank0_valid", 32'(valid), 32'd0);
    tick();
    check("ch0_shown", 32'(result), 32'b101);
    check("ch0_valid", 32'(valid), 32'd1);

    // Manual switch to channel 2
    set_chan(2, 3'b011);
    sel = 2'd2;
    tick();
    check("sw_active", 32'(active), 32'd2);
    check("sw_blank", 32'(valid), 32'd0);
    tick();
    tick();
    check("ch2_shown", 32'(result), 32'b011);

    // Out-of-range select is ignored
    sel = 2'd3;
    for (int i = 0; i < 20; i++) begin
      ch_data = CH*W'($urandom);
      tick();
      check("oor_valid", 32'(valid), 32'd1);
      check("oor_active", 32'(active), 32'd2);
    end

    // Reset in the middle of a blank
    sel = 2'd1;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    sel = 2'd0;
    tick();
    tick();
    check("midrst_ch0", 32'(valid), 32'd1);

    // Data follow with one-cycle latency
    for (int i = 0; i < 20; i++) begin
      ch_data = CH*W'($urandom);
      tick();
      check("follow_valid", 32'(valid), 32'd1);
    end

    // Auto-scan with sel noise, including the wrap from the last channel
    auto = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sel = SW'($urandom);
      ch_data = CH*W'($urandom);
      tick();
    end

    // Back to manual, then a random mix with occasional resets
    auto = 1'b0;
    sel = SW'(m_active);
    wait_hold();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) auto = ~auto;
      if ($urandom_range(0, 3) == 0) sel = SW'($urandom);
      ch_data = CH*W'($urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
